// File: rtl/filt_cicd_decim.sv
// filt_cicd_decim -- N-stage CIC (Hogenauer) decimator.
//   Integrators run on every enabled i_clk cycle; the last integrator is
//   sampled once per R-cycle frame, differentiated by N comb stages, and the
//   result is presented on o_data, held for one frame.
// Ports:
//   i_clk     sole clock, rising edge
//   i_rst_an  synchronous reset, active-high, priority over i_ena
//   i_ena     clock enable; low freezes every register
//   i_data    signed input sample (gp_inp_width)
//   o_data    signed decimated output (gp_oup_width), full precision
// w_sclk is a registered decimated-rate marker (high for the first half of
// each frame); o_data changes on the edge where w_sclk rises.
module filt_cicd_decim #(
  parameter int gp_decimation_factor = 8,
  parameter int gp_order             = 3,
  parameter int gp_diff_delay        = 1,
  parameter int gp_phase             = 0,
  parameter int gp_inp_width         = 16,
  parameter int gp_oup_width         = gp_inp_width
                                       + gp_order * $clog2(gp_decimation_factor * gp_diff_delay)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_an,
  input  logic                    i_ena,
  input  logic [gp_inp_width-1:0] i_data,
  output logic [gp_oup_width-1:0] o_data
);

  localparam int R  = gp_decimation_factor;
  localparam int N  = gp_order;
  localparam int M  = gp_diff_delay;
  localparam int W  = gp_oup_width;
  localparam int CW = (R > 2) ? $clog2(R) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(R - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(R / 2);
  localparam logic [CW-1:0] SLOT_SMP  = CW'(gp_phase);
  localparam logic [CW-1:0] SLOT_COMB = CW'((gp_phase + 1) % R);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_sclk;
  logic          sclk_d;
  logic          out_upd;
  logic [W-1:0]  x_ext;
  logic [W-1:0]  integ_q [N];
  logic [W-1:0]  dec_q;
  logic [W-1:0]  comb_q  [N];
  logic [W-1:0]  comb_in [N];
  logic [W-1:0]  dly_q   [N][M];
  logic [W-1:0]  o_data_q;

  always_comb begin
    x_ext   = {{(W - gp_inp_width){i_data[gp_inp_width-1]}}, i_data};
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    sclk_d  = (cnt_q < CNT_HALF);
    // Output refresh is tied to the marker's rising edge so both move together.
    out_upd = sclk_d & ~w_sclk;
    comb_in[0] = dec_q;
    for (int unsigned k = 1; k < N; k++) begin
      comb_in[k] = comb_q[k-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_an) begin
      cnt_q    <= '0;
      w_sclk   <= 1'b0;
      dec_q    <= '0;
      o_data_q <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        comb_q[k]  <= '0;
        for (int unsigned m = 0; m < M; m++) begin
          dly_q[k][m] <= '0;
        end
      end
    end else if (i_ena) begin
      cnt_q  <= cnt_d;
      w_sclk <= sclk_d;

      integ_q[0] <= integ_q[0] + x_ext;
      for (int unsigned k = 1; k < N; k++) begin
        integ_q[k] <= integ_q[k] + integ_q[k-1];
      end

      if (cnt_q == SLOT_SMP) begin
        dec_q <= integ_q[N-1];
      end

      // Pipelined comb cascade: each stage registered, all advance together
      // once per frame; delay line entry M-1 is the stage input M frames ago.
      if (cnt_q == SLOT_COMB) begin
        for (int unsigned k = 0; k < N; k++) begin
          comb_q[k]   <= comb_in[k] - dly_q[k][M-1];
          dly_q[k][0] <= comb_in[k];
          for (int unsigned m = 1; m < M; m++) begin
            dly_q[k][m] <= dly_q[k][m-1];
          end
        end
      end

      if (out_upd) begin
        o_data_q <= comb_q[N-1];
      end
    end
  end

  assign o_data = o_data_q;

endmodule

// File: tb/tb_filt_cicd_decim.sv
module tb_filt_cicd_decim;

  localparam int RA = 8,  NA = 3, MA = 1, PA = 0, WA = 25;
  localparam int RB = 16, NB = 4, MB = 2, PB = 3, WB = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ena;
  logic [15:0]   da, db;
  logic [WA-1:0] oa;
  logic [WB-1:0] ob;

  filt_cicd_decim #(
    .gp_decimation_factor(RA), .gp_order(NA), .gp_diff_delay(MA),
    .gp_phase(PA), .gp_inp_width(16), .gp_oup_width(WA)
  ) dut_a (
    .i_clk(clk), .i_rst_an(rst), .i_ena(ena), .i_data(da), .o_data(oa)
  );

  filt_cicd_decim #(
    .gp_decimation_factor(RB), .gp_order(NB), .gp_diff_delay(MB),
    .gp_phase(PB), .gp_inp_width(16), .gp_oup_width(WB)
  ) dut_b (
    .i_clk(clk), .i_rst_an(rst), .i_ena(ena), .i_data(db), .o_data(ob)
  );

  int     checks = 0;
  int     errors = 0;
  int     xa[$], xb[$];       // input history, enabled cycles since reset
  longint ha[$], hb[$];       // full-rate impulse response of H(z)
  longint expa, expb;
  bit     wa, wb;

  // H(z) = (sum_{i<RM} z^-i)^N, expanded by repeated polynomial multiply.
  function automatic void build_h(input int R, input int N, input int M, output longint h[$]);
    longint nq[$];
    h = {};
    h.push_back(1);
    repeat (N) begin
      nq = {};
      for (int i = 0; i < h.size() + R * M - 1; i++) nq.push_back(0);
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < R * M; j++) nq[i+j] += h[i];
      h = nq;
    end
  endfunction

  // Value o_data takes on the update edge of enabled cycle u (u multiple of R):
  // the latest comb run before u processed the integrator output from the
  // preceding cycle; the comb pipeline adds N-1 frames, integrators add N cycles.
  function automatic longint model_out(input int sel, input int u);
    int R, N, P, p1, k, tc, T, idx;
    longint acc;
    R = sel ? RB : RA; N = sel ? NB : NA; P = sel ? PB : PA;
    if (u == 0) return 0;
    p1  = (P + 1) % R;
    k   = (u - 1 - p1) / R;
    tc  = k * R + p1;
    T   = tc - 1 - (N - 1) * R - N;
    acc = 0;
    if (sel == 0) begin
      for (int i = 0; i < ha.size(); i++) begin
        idx = T - i;
        if (idx >= 0) acc += ha[i] * xa[idx];
      end
    end else begin
      for (int i = 0; i < hb.size(); i++) begin
        idx = T - i;
        if (idx >= 0) acc += hb[i] * xb[idx];
      end
    end
    return acc;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic e, input logic r);
    int t;
    da = a; db = b; ena = e; rst = r;
    @(posedge clk);
    if (r) begin
      xa = {}; xb = {};
      expa = 0; expb = 0; wa = 0; wb = 0;
    end else if (e) begin
      t  = xa.size();
      wa = (t % RA) < RA / 2;
      wb = (t % RB) < RB / 2;
      if (t % RA == 0) expa = model_out(0, t);
      if (t % RB == 0) expb = model_out(1, t);
      xa.push_back(int'($signed(a)));
      xb.push_back(int'($signed(b)));
    end
    #1;
    chk("o_data_a", longint'($signed(oa)), expa);
    chk("o_data_b", longint'($signed(ob)), expb);
    chk("w_sclk_a", longint'(dut_a.w_sclk), longint'(wa));
    chk("w_sclk_b", longint'(dut_b.w_sclk), longint'(wb));
  endtask

  initial begin
    int     rise1, rise2, n;
    bit     prev;
    longint sum_d, sum_m;
    logic [WA-1:0] hold_o;
    logic          hold_w;

    build_h(RA, NA, MA, ha);
    build_h(RB, NB, MB, hb);
    rst = 1'b1; ena = 1'b1; da = '0; db = '0;

    // Reset with enable high
    repeat (3) step(16'h0, 16'h0, 1'b1, 1'b1);
    chk("rst_cnt", longint'(dut_a.cnt_q), 0);

    // Marker period after release
    rise1 = -1; rise2 = -1; prev = dut_a.w_sclk;
    for (int c = 0; c < 20; c++) begin
      step(16'h0, 16'h0, 1'b1, 1'b0);
      if (dut_a.w_sclk && !prev) begin
        if (rise1 < 0) rise1 = c; else if (rise2 < 0) rise2 = c;
      end
      prev = dut_a.w_sclk;
    end
    chk("sclk_period", longint'(rise2 - rise1), 8);

    // DC step
    repeat (2) step(16'h0, 16'h0, 1'b1, 1'b1);
    repeat (12 * RA) step(16'd1, 16'd1, 1'b1, 1'b0);
    chk("dc_step", longint'($signed(oa)), 512);

    // Negative full scale
    repeat (2) step(16'h0, 16'h0, 1'b1, 1'b1);
    repeat (14 * RA) step(16'h8000, 16'h8000, 1'b1, 1'b0);
    chk("neg_fs", longint'($signed(oa)), -16777216);

    // Impulse at slot gp_phase (0)
    repeat (2) step(16'h0, 16'h0, 1'b1, 1'b1);
    sum_d = 0; sum_m = 0; prev = dut_a.w_sclk;
    step(16'd1, 16'd0, 1'b1, 1'b0);
    for (int c = 0; c < 10 * RA; c++) begin
      if (dut_a.w_sclk && !prev) begin
        sum_d += longint'($signed(oa));
        sum_m += expa;
      end
      prev = dut_a.w_sclk;
      step(16'd0, 16'd0, 1'b1, 1'b0);
    end
    chk("impulse_sum", sum_d, sum_m);
    chk("impulse_tail", longint'($signed(oa)), 0);

    // Enable gating mid-frame: everything frozen, then resumes seamlessly
    repeat (2) step(16'h0, 16'h0, 1'b1, 1'b1);
    repeat (4 * RA + 3) step(16'($urandom()), 16'($urandom()), 1'b1, 1'b0);
    hold_o = oa; hold_w = dut_a.w_sclk;
    n = int'(dut_a.cnt_q);
    repeat (5) step(16'($urandom()), 16'($urandom()), 1'b0, 1'b0);
    chk("gate_o", longint'($signed(oa)), longint'($signed(hold_o)));
    chk("gate_w", longint'(dut_a.w_sclk), longint'(hold_w));
    chk("gate_cnt", longint'(dut_a.cnt_q), longint'(n));
    repeat (6 * RA) step(16'($urandom()), 16'($urandom()), 1'b1, 1'b0);

    // Reset mid-frame, also with enable low (reset has priority)
    repeat (5) step(16'($urandom()), 16'($urandom()), 1'b1, 1'b0);
    step(16'h1234, 16'h4321, 1'b0, 1'b1);
    chk("midrst_cnt", longint'(dut_a.cnt_q), 0);
    chk("midrst_o", longint'($signed(oa)), 0);

    // Random stimulus, both configurations, occasional enable drops
    for (int c = 0; c < 10000; c++) begin
      step(16'($urandom()), 16'($urandom()), ($urandom_range(0, 15) != 0), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
